piso_reader: RTL and testbench
==============================

PISO_READER -- requirements
Module: piso_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bits in the parallel word (legal range 2..32).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1, which selects bit 0 first when 1 and bit WIDTH-1 first when 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port d, input, WIDTH bits: the parallel word to be read out.
REQ-006 The block SHALL have port set, input, 1 bit: synchronous force-ones qualifier, sampled only together with an accepted start.
REQ-007 The block SHALL have port start, input, 1 bit: request to capture and serialise a word.
REQ-008 The block SHALL have port sout, output, 1 bit: the serial data output.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a word is being shifted out.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE, a WIDTH-bit shift register, and a bit counter of ceil(log2(WIDTH)) bits.
REQ-012 All outputs SHALL be decoded from registered state only, with no combinational path from d, set or start to any output.
REQ-013 In IDLE the outputs SHALL be sout=0, busy=0 and done=0.
REQ-014 On a rising edge in IDLE with start=1, the block SHALL load the shift register with all ones if set=1 and with d otherwise, clear the counter to 0, and enter SHIFT.
REQ-015 On a rising edge in IDLE with start=0, the block SHALL hold IDLE, and set SHALL have no effect.
REQ-016 In SHIFT the block SHALL drive busy=1 and drive sout from the current output bit: shreg[0] when LSB_FIRST=1, shreg[WIDTH-1] otherwise.
REQ-017 On each rising edge in SHIFT the block SHALL shift the register one position toward the output end, fill the vacated bit with 0, and increment the counter.
REQ-018 On the rising edge in SHIFT where counter = WIDTH-1, the block SHALL enter DONE; the counter SHALL never wrap within a transfer.
REQ-019 The timing SHALL be as follows: bit k (k = 0..WIDTH-1, in transmission order) is valid on sout during the k-th cycle after the start-accept edge, so the first bit is valid one cycle after start is sampled.
REQ-020 In DONE the block SHALL hold done=1, busy=0 and sout=0 for exactly one cycle, then unconditionally return to IDLE.
REQ-021 The block SHALL ignore start and set while in SHIFT or DONE; no queuing occurs, and d changes after capture SHALL NOT affect the transfer.
REQ-022 Back-to-back transfers SHALL require start to be re-sampled in IDLE, giving a minimum start-to-start spacing of WIDTH+2 cycles.
REQ-023 The sequence for a held start SHALL be as follows: if start stays high, a new transfer begins on the first edge after DONE returns to IDLE.

Reset
REQ-024 When rst=1, the block SHALL immediately, without waiting for clk, force state=IDLE, shift register=0, counter=0, sout=0, busy=0 and done=0.
REQ-025 A reset asserted during SHIFT or DONE SHALL abort the transfer, and no done pulse SHALL be produced for the aborted word.
REQ-026 While rst is held high, the block SHALL ignore start and set.
REQ-027 After rst deasserts, the first start SHALL be accepted on the first rising edge that samples start=1.

Verification
REQ-028 The bench SHALL cover the LSB-first case: WIDTH=8, d=8'hA5, set=0, one-cycle start -> sout = 1,0,1,0,0,1,0,1 on cycles 1..8 after the accept edge, busy high for cycles 1..8, done high in cycle 9 only.
REQ-029 The bench SHALL cover the MSB-first case: LSB_FIRST=0, d=8'hA5 -> sout = 1,0,1,0,0,1,0,1 on cycles 1..8 (MSB first), busy and done as in REQ-028.
REQ-030 The bench SHALL cover forced ones: set=1 with start, d=8'h00 -> sout = 1 for all 8 shift cycles, then done pulses.
REQ-031 The bench SHALL cover input changes mid-transfer: d changes and start/set pulses during SHIFT -> output sequence unchanged from the captured word, and no extra transfer follows.
REQ-032 The bench SHALL cover asynchronous abort: rst pulsed between clock edges during bit 4 -> sout, busy and done go 0 before the next edge, no done pulse follows, and a new start with d=8'h3C then serialises correctly.
REQ-033 The bench SHALL cover held start: start held high over 3 transfers -> accept edges exactly 10 cycles apart (WIDTH+2), with one done pulse per transfer.

Source files
------------

// File: rtl/piso_reader.sv
// Parallel-in serial-out reader: captures a word (or all ones) on start and
// shifts it out one bit per cycle, then pulses done for one cycle.
module piso_reader #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             set,
  input  logic             start,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    cnt, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs depend only on registered state, so nothing from d/set/start leaks through.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    sout       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_next = set ? '1 : d;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (LSB_FIRST) begin
          sout       = shreg[0];
          shreg_next = {1'b0, shreg[WIDTH-1:1]};
        end else begin
          sout       = shreg[WIDTH-1];
          shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end
        // Hold the counter on the last bit so it never wraps.
        if (cnt == LAST) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_reader.sv
// Directed bench for piso_reader: one LSB-first and one MSB-first instance
// share the same inputs and are checked against hand-written bit sequences.
module tb_piso_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d = 8'h00;
  logic       set = 1'b0;
  logic       start = 1'b0;
  logic       sout_l, busy_l, done_l;
  logic       sout_m, busy_m, done_m;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  piso_reader #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .d(d), .set(set), .start(start),
    .sout(sout_l), .busy(busy_l), .done(done_l)
  );

  piso_reader #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .d(d), .set(set), .start(start),
    .sout(sout_m), .busy(busy_m), .done(done_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_cycle(input string tag, input logic exp_sl, input logic exp_sm,
                             input logic exp_busy, input logic exp_done);
    check_output({tag, "_sout_lsb"}, {31'd0, sout_l}, {31'd0, exp_sl});
    check_output({tag, "_sout_msb"}, {31'd0, sout_m}, {31'd0, exp_sm});
    check_output({tag, "_busy_lsb"}, {31'd0, busy_l}, {31'd0, exp_busy});
    check_output({tag, "_busy_msb"}, {31'd0, busy_m}, {31'd0, exp_busy});
    check_output({tag, "_done_lsb"}, {31'd0, done_l}, {31'd0, exp_done});
    check_output({tag, "_done_msb"}, {31'd0, done_m}, {31'd0, exp_done});
  endtask

  // Leaves the bench one cycle after the accept edge (first bit on sout).
  task automatic apply_stimulus(input logic [7:0] word, input logic force_ones);
    d     = word;
    set   = force_ones;
    start = 1'b1;
    tick();
    start = 1'b0;
    set   = 1'b0;
  endtask

  // Sequences are in transmission order, first bit in bit 7.
  task automatic expect_transfer(input string tag, input logic [7:0] seq_l,
                                 input logic [7:0] seq_m, input bit disturb);
    for (int k = 0; k < 8; k++) begin
      check_cycle($sformatf("%s_bit%0d", tag, k), seq_l[7-k], seq_m[7-k], 1'b1, 1'b0);
      if (disturb) begin
        d     = ~d ^ 8'h11;
        start = ~start;
        set   = ~set;
      end
      tick();
    end
    check_cycle({tag, "_done"}, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    set   = 1'b0;
    tick();
    check_cycle({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  nrise;
    int  ndone;
    int  r1, r2, r3;
    logic prev_busy;

    // Reset takes effect without a clock edge and holds off start/set.
    #2;
    rst = 1'b1;
    #1;
    check_cycle("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
    d     = 8'h00;
    set   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    check_cycle("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;

    // Start already high at release: accepted on the first edge, with forced ones.
    tick();
    start = 1'b0;
    set   = 1'b0;
    expect_transfer("ones", 8'hFF, 8'hFF, 1'b0);

    set = 1'b1;
    tick();
    check_cycle("idle_set1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_cycle("idle_set2", 1'b0, 1'b0, 1'b0, 1'b0);
    set = 1'b0;

    apply_stimulus(8'hA5, 1'b0);
    expect_transfer("a5", 8'b10100101, 8'b10100101, 1'b0);

    apply_stimulus(8'h01, 1'b0);
    expect_transfer("b01", 8'b10000000, 8'b00000001, 1'b0);

    // 8'h2D: LSB order 1,0,1,1,0,1,0,0 and MSB order 0,0,1,0,1,1,0,1.
    apply_stimulus(8'h2D, 1'b0);
    expect_transfer("disturb", 8'b10110100, 8'b00101101, 1'b1);
    tick();
    check_cycle("no_extra1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_cycle("no_extra2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort between edges while bit 4 is on the line.
    apply_stimulus(8'hA5, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check_cycle("pre_abort", 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_cycle("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_cycle($sformatf("post_abort%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    apply_stimulus(8'h3C, 1'b0);
    expect_transfer("b3c", 8'b00111100, 8'b00111100, 1'b0);

    // Held start: accepts at cycles 1, 11, 21; start drops during the third DONE.
    nrise     = 0;
    ndone     = 0;
    r1        = 0;
    r2        = 0;
    r3        = 0;
    prev_busy = 1'b0;
    d         = 8'hA5;
    start     = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (busy_l && !prev_busy) begin
        nrise++;
        if (nrise == 1) r1 = i;
        if (nrise == 2) r2 = i;
        if (nrise == 3) r3 = i;
      end
      if (done_l) ndone++;
      prev_busy = busy_l;
      if (i == 29) start = 1'b0;
    end
    check_output("held_accepts", nrise, 32'd3);
    check_output("held_first", r1, 32'd1);
    check_output("held_gap1", r2 - r1, 32'd10);
    check_output("held_gap2", r3 - r2, 32'd10);
    check_output("held_dones", ndone, 32'd3);
    tick();
    check_cycle("held_end", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
